datapath_pipe: RTL and testbench
================================

Name: datapath_pipe

Overview:
Parametrised two-stage successor to the single-cycle 8-bit datapath. It contains a register file of 2**ADDR_W entries of DATA_W bits, with R0 hardwired to zero. An issue/execute stage reads operands, runs the ALU and selects the writeback source. A registered writeback stage commits results one edge later, with writeback-to-issue forwarding, and registered status flags are added for the branch unit.

Parameters:
DATA_W, 8, datapath and register width (>=4)
ADDR_W, 4, register address width; register count = 2**ADDR_W

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
alu_opcode  in  3  ADD=000 SUB=001 AND=010 OR=011 XOR=100 NOT=101 SHL=110 SHR=111
ra_addr  in  ADDR_W  operand A register
rb_addr  in  ADDR_W  operand B register
write_addr  in  ADDR_W  destination register
write_en  in  1  issue a register write this cycle
write_alu  in  1  writeback source = ALU result
is_load  in  1  writeback source = ram_data (priority over write_alu)
alu_imm_flag  in  1  ALU operand B = imm_data instead of read_b
flag_we  in  1  update flags from this cycle's ALU result
imm_data  in  DATA_W  immediate
ram_data  in  DATA_W  load data
read_a  out  DATA_W  forwarded operand A (combinational)
read_b  out  DATA_W  forwarded operand B (combinational)
alu_out  out  DATA_W  combinational ALU result
wb_valid  out  1  writeback stage holds a pending write
hazard  out  1  RAW hazard against pending writeback (see Optional Feature)
alu_zero, alu_carry, alu_neg, alu_ovf  out  1 each  registered flags

Behaviour:
- Reset (async, immediate): all registers 0; writeback stage cleared (wb_valid=0); all four flags 0; hazard=0. Asserting reset during an operation discards any pending writeback.
- Writeback source select: is_load → ram_data, else write_alu → alu_out, else imm_data.
- Issue, at each edge with write_en=1 and write_addr!=0: capture wb_addr, wb_data=selected source, wb_valid=1. Otherwise wb_valid=0 at that edge.
- Commit: at each edge with wb_valid=1, regfile[wb_addr] ← wb_data. A value becomes architecturally visible two edges after issue.
- Writes to R0: dropped at issue, never enter the writeback stage; R0 always reads 0.
- Forwarding: read_x = 0 if addr_x=0; else wb_data if wb_valid and wb_addr==addr_x; else regfile[addr_x].
  - Back-to-back dependent ops therefore see the previous result with no bubble.
  - There is no same-cycle forwarding of the value being issued.
- ALU operand A = read_a. Operand B = alu_imm_flag ? imm_data : read_b. Width DATA_W, wrap-around.
- Flag rules, computed from the combinational result:
  - zero = (result==0).
  - neg = result MSB.
  - carry: ADD = carry-out. SUB = borrow (A<B unsigned). SHL = bit shifted out of MSB. SHR = bit shifted out of LSB. Logic ops and NOT = 0.
  - ovf = signed overflow for ADD/SUB, else 0.
- Flags are registered at the edge when flag_we=1 and otherwise hold. flag_we is independent of write_en, which allows compare-without-write.
- Simultaneous commit and issue to the same register: the new issue overwrites wb_data, and the older value still commits that edge. Net result is in-order.

Optional Feature:
Macro DATAPATH_FWD_EN.
- Defined: forwarding from the writeback stage as above; hazard tied 0.
- Undefined: no forwarding; read_x returns regfile only.
  - hazard=1 combinationally when wb_valid and wb_addr!=0 and wb_addr matches ra_addr, or matches rb_addr with alu_imm_flag=0.
  - Issuing logic must insert a bubble (write_en=0, flag_we=0) while hazard=1.
  - Datapath itself performs no stall.

Test Plan:
- Reset, then write R1..R15 = i*0x11 via imm on consecutive cycles. Two edges after the last write, a sweep of ra=i, rb=15-i reads the expected values; R0 reads 00.
- Forwarding: write R9=A4, next cycle ra=9. read_a=A4 while wb_valid=1, and the same value persists after commit. Without DATAPATH_FWD_EN, hazard=1 that cycle and read_a=0x99.
- R0: write_en=1, write_addr=0, imm=A4. wb_valid stays 0 and read_a/read_b at address 0 read 00 on all cycles.
- ADD chain: R1=0, R2=1, then 64 consecutive ADD R1=R1+R2 with flag_we=1. read_a increments 1 per cycle with no bubble; final R1=0x40; zero=0, carry=0.
- SUB chain: R2=0x0A, 13× SUB R1=R1-R2 from 0x40. Step 7 gives 0xFA with carry=1 and neg=1; final R1=0xBE. Then ADD 0x7F+imm 0x01 → 0x80 with ovf=1, neg=1, carry=0. Then SHL 0x81 → 0x02 with carry=1, and SHR 0x01 → 0x00 with zero=1, carry=1.
- Assert rst mid-cycle with a pending write of R5=0x33. wb_valid drops immediately; after release, R5 reads 00 and all flags are 0. Repeat with DATA_W=16, ADDR_W=3: 0xFFFF+0x0001 → 0x0000 with zero=1, carry=1.

Source files
------------

// File: rtl/datapath_pipe.sv
// Two-stage datapath: issue/execute with ALU and writeback select, then a registered writeback/commit stage.
// Optional macro DATAPATH_FWD_EN enables writeback-to-issue forwarding; otherwise hazard is reported.
package datapath_pipe_pkg;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;
endpackage

module datapath_pipe
    import datapath_pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        alu_opcode,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic              write_en,
    input  logic              write_alu,
    input  logic              is_load,
    input  logic              alu_imm_flag,
    input  logic              flag_we,
    input  logic [DATA_W-1:0] imm_data,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] read_a,
    output logic [DATA_W-1:0] read_b,
    output logic [DATA_W-1:0] alu_out,
    output logic              wb_valid,
    output logic              hazard,
    output logic              alu_zero,
    output logic              alu_carry,
    output logic              alu_neg,
    output logic              alu_ovf
);

    localparam int NREG = 2 ** ADDR_W;
    localparam int MSB  = DATA_W - 1;

    logic [DATA_W-1:0] regs [NREG];
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              fwd_a;
    logic              fwd_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic              carry_nx;
    logic              ovf_nx;
    logic [DATA_W-1:0] wr_data;
    logic              issue;

`ifdef DATAPATH_FWD_EN
    assign fwd_a  = wb_valid && (wb_addr == ra_addr);
    assign fwd_b  = wb_valid && (wb_addr == rb_addr);
    assign hazard = 1'b0;
`else
    assign fwd_a  = 1'b0;
    assign fwd_b  = 1'b0;
    assign hazard = wb_valid && (wb_addr != '0) &&
                    ((wb_addr == ra_addr) ||
                     ((wb_addr == rb_addr) && !alu_imm_flag));
`endif

    always_comb begin
        read_a = regs[ra_addr];
        if (ra_addr == '0) begin
            read_a = '0;
        end else if (fwd_a) begin
            read_a = wb_data;
        end
    end

    always_comb begin
        read_b = regs[rb_addr];
        if (rb_addr == '0) begin
            read_b = '0;
        end else if (fwd_b) begin
            read_b = wb_data;
        end
    end

    assign op_a = read_a;
    assign op_b = alu_imm_flag ? imm_data : read_b;
    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    // diff[DATA_W] is the borrow, i.e. op_a < op_b unsigned
    assign diff = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        alu_out  = '0;
        carry_nx = 1'b0;
        ovf_nx   = 1'b0;
        case (alu_opcode)
            OP_ADD: begin
                alu_out  = sum[MSB:0];
                carry_nx = sum[DATA_W];
                ovf_nx   = (op_a[MSB] == op_b[MSB]) &&
                           (sum[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                alu_out  = diff[MSB:0];
                carry_nx = diff[DATA_W];
                ovf_nx   = (op_a[MSB] != op_b[MSB]) &&
                           (diff[MSB] != op_a[MSB]);
            end
            OP_AND: alu_out = op_a & op_b;
            OP_OR:  alu_out = op_a | op_b;
            OP_XOR: alu_out = op_a ^ op_b;
            OP_NOT: alu_out = ~op_a;
            OP_SHL: begin
                alu_out  = {op_a[MSB-1:0], 1'b0};
                carry_nx = op_a[MSB];
            end
            OP_SHR: begin
                alu_out  = {1'b0, op_a[MSB:1]};
                carry_nx = op_a[0];
            end
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        wr_data = imm_data;
        if (is_load) begin
            wr_data = ram_data;
        end else if (write_alu) begin
            wr_data = alu_out;
        end
    end

    // R0 writes are dropped here so they never occupy the writeback stage
    assign issue = write_en && (write_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= issue;
            if (issue) begin
                wb_addr <= write_addr;
                wb_data <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_zero  <= 1'b0;
            alu_carry <= 1'b0;
            alu_neg   <= 1'b0;
            alu_ovf   <= 1'b0;
        end else if (flag_we) begin
            alu_zero  <= (alu_out == '0);
            alu_carry <= carry_nx;
            alu_neg   <= alu_out[MSB];
            alu_ovf   <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_datapath_pipe.sv
// Self-checking bench for datapath_pipe: directed scenarios plus random traffic
// against a queue-based behavioural model; a second 16-bit instance covers wide carry.
module tb_datapath_pipe;
    import datapath_pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] op;
    logic [3:0] ra, rb, wa;
    logic       we, wal, ld, immf, fwe;
    logic [7:0] imm, ram;
    logic [7:0] read_a, read_b, alu_out;
    logic       wb_valid, hazard, zf, cf, nf, vf;

    logic [2:0]  w_op;
    logic [2:0]  w_ra, w_rb, w_wa;
    logic        w_we, w_wal, w_ld, w_immf, w_fwe;
    logic [15:0] w_imm, w_ram;
    logic [15:0] w_read_a, w_read_b, w_alu_out;
    logic        w_wb_valid, w_hazard, w_z, w_c, w_n, w_v;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    datapath_pipe #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .alu_opcode(op),
        .ra_addr(ra), .rb_addr(rb), .write_addr(wa),
        .write_en(we), .write_alu(wal), .is_load(ld),
        .alu_imm_flag(immf), .flag_we(fwe),
        .imm_data(imm), .ram_data(ram),
        .read_a(read_a), .read_b(read_b), .alu_out(alu_out),
        .wb_valid(wb_valid), .hazard(hazard),
        .alu_zero(zf), .alu_carry(cf), .alu_neg(nf), .alu_ovf(vf)
    );

    datapath_pipe #(.DATA_W(16), .ADDR_W(3)) dut_w (
        .clk(clk), .rst(rst), .alu_opcode(w_op),
        .ra_addr(w_ra), .rb_addr(w_rb), .write_addr(w_wa),
        .write_en(w_we), .write_alu(w_wal), .is_load(w_ld),
        .alu_imm_flag(w_immf), .flag_we(w_fwe),
        .imm_data(w_imm), .ram_data(w_ram),
        .read_a(w_read_a), .read_b(w_read_b), .alu_out(w_alu_out),
        .wb_valid(w_wb_valid), .hazard(w_hazard),
        .alu_zero(w_z), .alu_carry(w_c), .alu_neg(w_n), .alu_ovf(w_v)
    );

    // Reference model: architectural registers plus a queue of pending writes
    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic [7:0] mr [16];
    wr_t        pq [$];
    logic       mz, mc, mn, mv;

    function automatic logic [7:0] m_read(input logic [3:0] ad);
        if (ad == 4'd0) return 8'h00;
`ifdef DATAPATH_FWD_EN
        if (pq.size() > 0 && pq[0].a == ad) return pq[0].d;
`endif
        return mr[ad];
    endfunction

    function automatic logic m_hazard();
`ifdef DATAPATH_FWD_EN
        return 1'b0;
`else
        if (pq.size() == 0) return 1'b0;
        return (pq[0].a == ra) || (pq[0].a == rb && !immf);
`endif
    endfunction

    task automatic m_alu(output logic [7:0] r, output logic c, output logic v);
        int a  = int'(m_read(ra));
        int b  = immf ? int'(imm) : int'(m_read(rb));
        int sa = (a >= 128) ? a - 256 : a;
        int sb = (b >= 128) ? b - 256 : b;
        int s;
        c = 1'b0;
        v = 1'b0;
        r = 8'h00;
        case (op)
            3'd0: begin
                r = 8'(a + b); c = (a + b) > 255;
                s = sa + sb;   v = (s > 127) || (s < -128);
            end
            3'd1: begin
                r = 8'(a - b); c = a < b;
                s = sa - sb;   v = (s > 127) || (s < -128);
            end
            3'd2: r = 8'(a & b);
            3'd3: r = 8'(a | b);
            3'd4: r = 8'(a ^ b);
            3'd5: r = 8'(255 - a);
            3'd6: begin r = 8'(a * 2); c = a >= 128; end
            default: begin r = 8'(a / 2); c = (a % 2) == 1; end
        endcase
    endtask

    task automatic m_edge();
        logic [7:0] r, src;
        logic       c, v;
        m_alu(r, c, v);
        src = ld ? ram : (wal ? r : imm);
        if (pq.size() > 0) begin
            mr[pq[0].a] = pq[0].d;
            pq.delete(0);
        end
        if (we && wa != 4'd0) pq.push_back('{a: wa, d: src});
        if (fwe) begin
            mz = (r == 8'h00);
            mn = (r >= 8'd128);
            mc = c;
            mv = v;
        end
    endtask

    task automatic m_reset();
        foreach (mr[i]) mr[i] = 8'h00;
        pq.delete();
        mz = 1'b0; mc = 1'b0; mn = 1'b0; mv = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [3:0] a, b, w,
                         input logic e, s, l, i, f,
                         input logic [7:0] m, d);
        op = o; ra = a; rb = b; wa = w;
        we = e; wal = s; ld = l; immf = i; fwe = f;
        imm = m; ram = d;
    endtask

    task automatic idle();
        drive(OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // Issuer-side bubble insertion while the pending write collides
    task automatic issue_safe();
        logic se, sf;
        for (int n = 0; n < 4 && m_hazard(); n++) begin
            se = we; sf = fwe;
            we = 1'b0; fwe = 1'b0;
            tick();
            we = se; fwe = sf;
        end
        if (m_hazard()) begin
            checks++; errors++;
            $display("FAIL bubble_bound: hazard still predicted after 4 bubbles");
        end
    endtask

    task automatic test_reset();
        idle();
        ra = 4'd3; rb = 4'd7;
        m_reset();
        #12;
        checks++;
        if ({wb_valid, hazard} !== 2'b00) begin
            errors++;
            $display("FAIL reset_wb: got %b want 00", {wb_valid, hazard});
        end
        checks++;
        if ({zf, cf, nf, vf} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {zf, cf, nf, vf});
        end
        checks++;
        if (read_a !== 8'h00 || read_b !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: got %h/%h want 00/00", read_a, read_b);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_fill();
        logic [7:0] ea, eb;
        for (int i = 1; i < 16; i++) begin
            drive(OP_ADD, 4'd0, 4'd0, 4'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                  8'(i * 17), 8'h00);
            tick();
        end
        idle();
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i); rb = 4'(15 - i);
            ea = 8'(i * 17); eb = 8'((15 - i) * 17);
            @(negedge clk);
            checks++;
            if (read_a !== ea || read_b !== eb) begin
                errors++;
                $display("FAIL fill_sweep%0d: got %h/%h want %h/%h",
                         i, read_a, read_b, ea, eb);
            end
            tick();
        end
    endtask

    task automatic test_forward();
        drive(OP_ADD, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA4, 8'h00);
        tick();
        idle();
        ra = 4'd9;
        @(negedge clk);
`ifdef DATAPATH_FWD_EN
        checks++;
        if (read_a !== 8'hA4 || wb_valid !== 1'b1 || hazard !== 1'b0) begin
            errors++;
            $display("FAIL fwd_pending: got %h v=%b hz=%b want a4 v=1 hz=0",
                     read_a, wb_valid, hazard);
        end
`else
        checks++;
        if (read_a !== 8'h99 || wb_valid !== 1'b1 || hazard !== 1'b1) begin
            errors++;
            $display("FAIL fwd_hazard: got %h v=%b hz=%b want 99 v=1 hz=1",
                     read_a, wb_valid, hazard);
        end
`endif
        tick();
        @(negedge clk);
        checks++;
        if (read_a !== 8'hA4 || wb_valid !== 1'b0 || hazard !== 1'b0) begin
            errors++;
            $display("FAIL fwd_commit: got %h v=%b hz=%b want a4 v=0 hz=0",
                     read_a, wb_valid, hazard);
        end
        tick();
    endtask

    task automatic test_r0();
        for (int k = 0; k < 3; k++) begin
            drive(OP_ADD, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                  8'hA4, 8'h00);
            @(negedge clk);
            checks++;
            if (wb_valid !== 1'b0 || read_a !== 8'h00 || read_b !== 8'h00) begin
                errors++;
                $display("FAIL r0_write%0d: got v=%b %h/%h want v=0 00/00",
                         k, wb_valid, read_a, read_b);
            end
            tick();
        end
    endtask

    task automatic test_add_chain();
        drive(OP_ADD, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        wa = 4'd2; imm = 8'h01;
        tick();
        for (int k = 0; k < 64; k++) begin
            drive(OP_ADD, 4'd1, 4'd2, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                  8'h00, 8'h00);
            issue_safe();
            @(negedge clk);
            checks++;
            if (read_a !== 8'(k) || alu_out !== 8'(k + 1)) begin
                errors++;
                $display("FAIL add_step%0d: got %h->%h want %h->%h",
                         k, read_a, alu_out, 8'(k), 8'(k + 1));
            end
            tick();
        end
        checks++;
        if (zf !== 1'b0 || cf !== 1'b0) begin
            errors++;
            $display("FAIL add_flags: got z=%b c=%b want 0 0", zf, cf);
        end
        idle();
        tick();
        tick();
        ra = 4'd1;
        @(negedge clk);
        checks++;
        if (read_a !== 8'h40) begin
            errors++;
            $display("FAIL add_final: got %h want 40", read_a);
        end
        tick();
    endtask

    task automatic test_sub_chain();
        drive(OP_ADD, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0A, 8'h00);
        tick();
        for (int k = 1; k <= 13; k++) begin
            drive(OP_SUB, 4'd1, 4'd2, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                  8'h00, 8'h00);
            issue_safe();
            @(negedge clk);
            checks++;
            if (alu_out !== 8'(64 - 10 * k)) begin
                errors++;
                $display("FAIL sub_step%0d: got %h want %h",
                         k, alu_out, 8'(64 - 10 * k));
            end
            tick();
            if (k == 7) begin
                checks++;
                if (cf !== 1'b1 || nf !== 1'b1 || zf !== 1'b0) begin
                    errors++;
                    $display("FAIL sub_borrow: got c=%b n=%b z=%b want 1 1 0",
                             cf, nf, zf);
                end
            end
        end
        idle();
        tick();
        tick();
        ra = 4'd1;
        @(negedge clk);
        checks++;
        if (read_a !== 8'hBE) begin
            errors++;
            $display("FAIL sub_final: got %h want be", read_a);
        end
        tick();

        drive(OP_ADD, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h00);
        tick();
        drive(OP_ADD, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h00);
        issue_safe();
        @(negedge clk);
        checks++;
        if (alu_out !== 8'h80) begin
            errors++;
            $display("FAIL ovf_result: got %h want 80", alu_out);
        end
        tick();
        checks++;
        if ({vf, nf, cf} !== 3'b110) begin
            errors++;
            $display("FAIL ovf_flags: got vnc=%b want 110", {vf, nf, cf});
        end

        drive(OP_ADD, 4'd0, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 8'h00);
        tick();
        drive(OP_SHL, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        issue_safe();
        @(negedge clk);
        checks++;
        if (alu_out !== 8'h02) begin
            errors++;
            $display("FAIL shl_result: got %h want 02", alu_out);
        end
        tick();
        checks++;
        if (cf !== 1'b1 || zf !== 1'b0) begin
            errors++;
            $display("FAIL shl_flags: got c=%b z=%b want 1 0", cf, zf);
        end

        drive(OP_ADD, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h00);
        tick();
        drive(OP_SHR, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        issue_safe();
        @(negedge clk);
        checks++;
        if (alu_out !== 8'h00) begin
            errors++;
            $display("FAIL shr_result: got %h want 00", alu_out);
        end
        tick();
        checks++;
        if (cf !== 1'b1 || zf !== 1'b1) begin
            errors++;
            $display("FAIL shr_flags: got c=%b z=%b want 1 1", cf, zf);
        end
    endtask

    task automatic test_reset_mid();
        drive(OP_ADD, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 8'h00);
        tick();
        idle();
        checks++;
        if (wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pending: got v=%b want 1", wb_valid);
        end
        #2 rst = 1'b1;
        m_reset();
        #1;
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop: got v=%b want 0", wb_valid);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        ra = 4'd5;
        @(negedge clk);
        checks++;
        if (read_a !== 8'h00 || {zf, cf, nf, vf} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_after: got %h flags=%b want 00 0000",
                     read_a, {zf, cf, nf, vf});
        end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic       c, v;
        for (int n = 0; n < 300; n++) begin
            drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            @(negedge clk);
            m_alu(r, c, v);
            checks++;
            if (read_a !== m_read(ra) || read_b !== m_read(rb)) begin
                errors++;
                $display("FAIL rnd_read%0d: got %h/%h want %h/%h",
                         n, read_a, read_b, m_read(ra), m_read(rb));
            end
            checks++;
            if (alu_out !== r) begin
                errors++;
                $display("FAIL rnd_alu%0d: op=%0d got %h want %h",
                         n, op, alu_out, r);
            end
            checks++;
            if (hazard !== m_hazard() || wb_valid !== (pq.size() > 0)) begin
                errors++;
                $display("FAIL rnd_ctl%0d: got hz=%b v=%b want hz=%b v=%b",
                         n, hazard, wb_valid, m_hazard(), pq.size() > 0);
            end
            tick();
            checks++;
            if ({zf, cf, nf, vf} !== {mz, mc, mn, mv}) begin
                errors++;
                $display("FAIL rnd_flags%0d: got %b want %b",
                         n, {zf, cf, nf, vf}, {mz, mc, mn, mv});
            end
        end
        idle();
    endtask

    task automatic test_wide();
        w_wa = 3'd1; w_imm = 16'hFFFF; w_we = 1'b1;
        @(posedge clk);
        #1 w_wa = 3'd2; w_imm = 16'h0001;
        @(posedge clk);
        #1 w_we = 1'b0;
        @(posedge clk);
        #1 w_op = OP_ADD; w_ra = 3'd1; w_rb = 3'd2; w_fwe = 1'b1;
        @(negedge clk);
        checks++;
        if (w_read_a !== 16'hFFFF || w_read_b !== 16'h0001) begin
            errors++;
            $display("FAIL wide_regs: got %h/%h want ffff/0001", w_read_a, w_read_b);
        end
        checks++;
        if (w_alu_out !== 16'h0000 || w_wb_valid !== 1'b0 || w_hazard !== 1'b0) begin
            errors++;
            $display("FAIL wide_add: got %h v=%b hz=%b want 0000 v=0 hz=0",
                     w_alu_out, w_wb_valid, w_hazard);
        end
        @(posedge clk);
        #1 w_fwe = 1'b0;
        checks++;
        if ({w_z, w_c, w_n, w_v} !== 4'b1100) begin
            errors++;
            $display("FAIL wide_flags: got zcnv=%b want 1100", {w_z, w_c, w_n, w_v});
        end
    endtask

    initial begin
        w_op = OP_ADD; w_ra = 3'd0; w_rb = 3'd0; w_wa = 3'd0;
        w_we = 1'b0; w_wal = 1'b0; w_ld = 1'b0; w_immf = 1'b0; w_fwe = 1'b0;
        w_imm = 16'h0000; w_ram = 16'h0000;
        test_reset();
        test_fill();
        test_forward();
        test_r0();
        test_add_chain();
        test_sub_chain();
        test_reset_mid();
        test_random();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
